mem_port_arbiter: RTL

- Shares one single-ported 16-bit-word memory between the instruction-fetch requester and the data (load/store) requester.
- Each 32-bit instruction is assembled from two sequential 16-bit reads.
- Data accesses take priority; a starvation counter guarantees fetch progress.
- Sits between the processor core (pc/instr and MR/MW/aluOut/readData2 side) and the unified memory.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 16-bit memory between the
// instruction fetch side and the data load/store side.
// Ports: clk, reset (sync, active-high)
//        if_req/if_addr -> if_ready/if_instr  (32-bit instr from two reads)
//        d_rd/d_wr/d_addr/d_wdata -> d_ready/d_rdata
//        mem_addr/mem_re/mem_we/mem_wdata <- mem_rdata (one-cycle read latency)
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_ready,
   output logic [31:0]       if_instr,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [15:0]       d_addr,
   input  logic [15:0]       d_wdata,
   output logic              d_ready,
   output logic [15:0]       d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, F1, F2, DRD} state_t;

   localparam logic [3:0]        MaxRun  = 4'(MAX_DATA_RUN);
   localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

   state_t            state;
   state_t            nextState;
   logic [15:0]       hiReg;
   logic [3:0]        starveCnt;
   logic              dataReq;
   logic              fetchForced;
   logic              dataGrant;
   logic              fetchGrant;
   logic [ADDR_W-1:0] ifAddrW;
   logic [ADDR_W-1:0] dAddrW;
   logic              unusedIfAddr;

   assign ifAddrW      = if_addr[ADDR_W-1:0];
   assign dAddrW       = ADDR_W'(d_addr);
   assign unusedIfAddr = ^if_addr[31:ADDR_W];

   // Data wins in IDLE unless the fetch side has waited out its run.
   assign dataReq     = d_rd | d_wr;
   assign fetchForced = if_req & (starveCnt == MaxRun);
   assign dataGrant   = (state == IDLE) & dataReq & ~fetchForced;
   assign fetchGrant  = (state == IDLE) & ~dataGrant & if_req;

   always_comb begin
      nextState = state;
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      d_ready   = 1'b0;
      d_rdata   = '0;
      if_ready  = 1'b0;
      if_instr  = '0;
      unique case (state)
         IDLE: begin
            // d_rd has precedence so a bogus rd+wr never writes.
            if (dataGrant && d_rd) begin
               mem_re    = 1'b1;
               mem_addr  = dAddrW;
               nextState = DRD;
            end else if (dataGrant) begin
               mem_we    = 1'b1;
               mem_addr  = dAddrW;
               mem_wdata = d_wdata;
               d_ready   = 1'b1;
            end else if (fetchGrant) begin
               mem_re    = 1'b1;
               mem_addr  = ifAddrW;
               nextState = F1;
            end
         end
         F1: begin
            mem_re    = 1'b1;
            mem_addr  = ifAddrW + AddrOne;
            nextState = F2;
         end
         F2: begin
            if_ready  = 1'b1;
            if_instr  = {hiReg, mem_rdata};
            nextState = IDLE;
         end
         DRD: begin
            d_ready   = 1'b1;
            d_rdata   = mem_rdata;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      // Reset silences everything, even mid-sequence.
      if (reset) begin
         nextState = IDLE;
         mem_addr  = '0;
         mem_re    = 1'b0;
         mem_we    = 1'b0;
         mem_wdata = '0;
         d_ready   = 1'b0;
         d_rdata   = '0;
         if_ready  = 1'b0;
         if_instr  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         hiReg     <= '0;
         starveCnt <= '0;
      end else begin
         state <= nextState;
         if (state == F1)
            hiReg <= mem_rdata;
         if (fetchGrant || (state == IDLE && !if_req))
            starveCnt <= '0;
         else if (dataGrant && starveCnt != MaxRun)
            starveCnt <= starveCnt + 4'd1;
      end
   end

endmodule
